vx_dxa_uop_seq: RTL

//  Parametrised DXA launch micro-op sequencer. It accepts one architected DXA launch op and expands
//  it into SETUP0, SETUP1, then ceil(ndims/2) coordinate uops; the final uop is ISSUE. It sits

---
 rtl/vx_dxa_uop_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vx_dxa_uop_seq.sv
// DXA launch micro-op sequencer.
// Expands one launch op into SETUP0, SETUP1 and ceil(ndims/2) coordinate uops.
// The final uop is ISSUE. Valid/ready is used on both sides.
// A new op can be accepted on the ISSUE fire, so back-to-back ops have no bubble.
module vx_dxa_uop_seq #(
    parameter int          MAX_DIMS    = 5,
    parameter int          COORD_BASE  = 5,
    parameter logic [1:0]  COORD_RTYPE = 2'd1,
    parameter int          RS_W        = 7,
    parameter int          ARGS_W      = 16,
    parameter int          META_W      = 64,
    parameter int          UUID_W      = 44,
    localparam int         MAX_UOPS    = 2 + (MAX_DIMS + 1) / 2,
    localparam int         CTR_W       = $clog2(MAX_UOPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RS_W-1:0]   in_rs1,
    input  logic [RS_W-1:0]   in_rs2,
    input  logic [2:0]        in_ndims,
    input  logic [ARGS_W-1:0] in_args,
    input  logic [META_W-1:0] in_meta,
    input  logic [UUID_W-1:0] in_uuid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_op,
    output logic [CTR_W-1:0]  out_idx,
    output logic [2:0]        out_used_rs,
    output logic [RS_W-1:0]   out_rs1,
    output logic [RS_W-1:0]   out_rs2,
    output logic [ARGS_W-1:0] out_args,
    output logic [META_W-1:0] out_meta,
    output logic [UUID_W-1:0] out_uuid,
    output logic              out_last,
    output logic              busy
);

    localparam int IDX_W = RS_W - 2;
    localparam int UHI_W = UUID_W - CTR_W;

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CTR_W-1:0]    r_ctr;
    logic [CTR_W-1:0]    r_last_idx;
    logic [3:0]          r_n;
    logic [RS_W-1:0]     r_rs1;
    logic [RS_W-1:0]     r_rs2;
    logic [ARGS_W-1:0]   r_args;
    logic [META_W-1:0]   r_meta;
    logic [UHI_W-1:0]    r_uuid_hi;

    logic                w_busy;
    logic                w_fire;
    logic                w_last;
    logic                w_accept;
    int                  w_n_in;
    logic [CTR_W:0]      w_pair2;
    logic                w_has_c1;
    logic [RS_W-1:0]     w_c0;
    logic [RS_W-1:0]     w_c1;
    logic                w_unused_uuid_lo;

    // ndims of 0 means one dimension; anything above MAX_DIMS saturates.
    function automatic int clamp_dims(input logic [2:0] nd);
        if (nd == 3'd0) return 1;
        if (int'(nd) > MAX_DIMS) return MAX_DIMS;
        return int'(nd);
    endfunction

    assign w_busy           = (r_state == S_EXPAND);
    assign w_fire           = w_busy & out_ready;
    assign w_last           = w_busy & (r_ctr == r_last_idx);
    assign w_accept         = in_valid & in_ready;
    assign w_n_in           = clamp_dims(in_ndims);
    assign w_unused_uuid_lo = ^in_uuid[CTR_W-1:0];

    // State register: IDLE/EXPAND.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: flush dominates; a same-cycle accept on the last uop keeps us expanding.
    always_comb begin
        w_state_nxt = r_state;
        if (flush)                 w_state_nxt = S_IDLE;
        else if (w_accept)         w_state_nxt = S_EXPAND;
        else if (w_fire && w_last) w_state_nxt = S_IDLE;
    end

    // Handshake outputs derived from the state.
    always_comb begin
        busy      = w_busy;
        out_valid = w_busy;
        in_ready  = ~flush & (~w_busy | (w_fire & w_last));
    end

    // Uop counter: restarts on accept, advances on each non-final fire, never wraps.
    always_ff @(posedge clk) begin
        if (reset || flush)         r_ctr <= '0;
        else if (w_accept)          r_ctr <= '0;
        else if (w_fire && !w_last) r_ctr <= r_ctr + CTR_W'(1);
    end

    // Latch the launch op fields on accept; reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n        <= '0;
            r_last_idx <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_args     <= '0;
            r_meta     <= '0;
            r_uuid_hi  <= '0;
        end else if (w_accept) begin
            r_n        <= 4'(w_n_in);
            r_last_idx <= CTR_W'(1 + (w_n_in + 1) / 2);
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_args     <= in_args;
            r_meta     <= in_meta;
            r_uuid_hi  <= in_uuid[UUID_W-1:CTR_W];
        end
    end

    // Decode the current uop from the counter; coordinate pairs start at counter 2.
    always_comb begin
        w_pair2  = {r_ctr - CTR_W'(2), 1'b0};
        w_has_c1 = (int'(w_pair2) + 1) < int'(r_n);
        w_c0     = {COORD_RTYPE, IDX_W'(COORD_BASE) + IDX_W'(w_pair2)};
        w_c1     = {COORD_RTYPE, IDX_W'(COORD_BASE) + IDX_W'(w_pair2) + IDX_W'(1)};

        out_idx  = r_ctr;
        out_args = r_args;
        out_meta = r_meta;
        out_uuid = {r_uuid_hi, r_ctr};
        out_last = w_last;

        if (r_ctr == CTR_W'(0)) begin
            out_op      = 3'd0;
            out_rs1     = r_rs2;
            out_rs2     = r_rs2;
            out_used_rs = 3'b011;
        end else if (r_ctr == CTR_W'(1)) begin
            out_op      = 3'd1;
            out_rs1     = r_rs1;
            out_rs2     = r_rs2;
            out_used_rs = 3'b011;
        end else begin
            out_op      = (r_ctr == r_last_idx) ? 3'd4 : 3'd2;
            out_rs1     = w_c0;
            out_rs2     = w_has_c1 ? w_c1 : '0;
            out_used_rs = w_has_c1 ? 3'b011 : 3'b001;
        end
    end

endmodule
